// File: rtl/axi_mem_arbiter_if.sv
// Bundle for axi_mem_arbiter: two-client request/response side plus the single-beat AXI4 master side.
// The master modport is the arbiter's view; slave is the environment (clients and AXI slave).
interface axi_mem_arbiter_if #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 32
);
   logic [1:0]                    REQ_VALID;
   logic [1:0]                    REQ_WE;
   logic [2*C_AXI_ADDR_WIDTH-1:0] REQ_ADDR;
   logic [2*C_AXI_DATA_WIDTH-1:0] REQ_WDATA;
   logic [1:0]                    REQ_READY;
   logic [1:0]                    RSP_VALID;
   logic [C_AXI_DATA_WIDTH-1:0]   RSP_RDATA;
   logic                          RSP_ERR;

   logic [C_AXI_ADDR_WIDTH-1:0]   AWADDR;
   logic                          AWVALID;
   logic                          AWREADY;
   logic [C_AXI_DATA_WIDTH-1:0]   WDATA;
   logic                          WVALID;
   logic                          WLAST;
   logic                          WREADY;
   logic [1:0]                    BRESP;
   logic                          BVALID;
   logic [C_AXI_ADDR_WIDTH-1:0]   ARADDR;
   logic                          ARVALID;
   logic                          ARREADY;
   logic [C_AXI_DATA_WIDTH-1:0]   RDATA;
   logic [1:0]                    RRESP;
   logic                          RVALID;
   logic                          RLAST;
   logic                          RREADY;

   modport master (
      input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID, RLAST,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
      output AWADDR, AWVALID, WDATA, WVALID, WLAST, ARADDR, ARVALID, RREADY
   );

   modport slave (
      output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID, RLAST,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
      input  AWADDR, AWVALID, WDATA, WVALID, WLAST, ARADDR, ARVALID, RREADY
   );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter for two single-word clients onto one AXI4 master port.
// One single-beat transaction is outstanding at a time; completion is pulsed back to the granted client.
module axi_mem_arbiter #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 32
) (
   input logic               CLK,
   input logic               RST,
   axi_mem_arbiter_if.master bus
);
   localparam int DW = C_AXI_DATA_WIDTH;
   localparam int AW = C_AXI_ADDR_WIDTH;

   localparam logic [2:0] IDLE         = 3'd0;
   localparam logic [2:0] WR_ADDR_DATA = 3'd1;
   localparam logic [2:0] WAIT_B       = 3'd2;
   localparam logic [2:0] RD_ADDR      = 3'd3;
   localparam logic [2:0] WAIT_R       = 3'd4;
   localparam logic [2:0] RESP         = 3'd5;

   logic [2:0]    state;
   logic          last_grant;
   logic          grant;
   logic          grant_q;
   logic          accept;
   logic          aw_valid;
   logic          w_valid;
   logic          ar_valid;
   logic          b_done;
   logic          wr_done;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_we;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic          err_q;
   logic          unused_ok;

   always_comb begin
      // NOTE: assign a default before the case so no input pattern leaves grant unassigned (latch).
      grant = 1'b0;
      case (bus.REQ_VALID)
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

   assign accept    = (state == IDLE) && (bus.REQ_VALID != 2'b00) && !RST;
   assign sel_addr  = grant ? bus.REQ_ADDR[2*AW-1:AW]  : bus.REQ_ADDR[AW-1:0];
   assign sel_wdata = grant ? bus.REQ_WDATA[2*DW-1:DW] : bus.REQ_WDATA[DW-1:0];
   assign sel_we    = bus.REQ_WE[grant];

   // A channel counts as finished if it already completed or handshakes in this cycle.
   assign wr_done = (!aw_valid || bus.AWREADY) && (!w_valid || bus.WREADY);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant_q    <= 1'b0;
         aw_valid   <= 1'b0;
         w_valid    <= 1'b0;
         ar_valid   <= 1'b0;
         b_done     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= only, so every branch sees the pre-edge register values.
         case (state)
            IDLE: begin
               if (accept) begin
                  grant_q    <= grant;
                  last_grant <= grant;
                  addr_q     <= sel_addr;
                  wdata_q    <= sel_wdata;
                  b_done     <= 1'b0;
                  if (sel_we) begin
                     aw_valid <= 1'b1;
                     w_valid  <= 1'b1;
                     state    <= WR_ADDR_DATA;
                  end else begin
                     ar_valid <= 1'b1;
                     state    <= RD_ADDR;
                  end
               end
            end
            WR_ADDR_DATA: begin
               if (aw_valid && bus.AWREADY) aw_valid <= 1'b0;
               if (w_valid && bus.WREADY)   w_valid  <= 1'b0;
               // An early write response is kept so it is not lost before WAIT_B.
               if (bus.BVALID) begin
                  b_done <= 1'b1;
                  err_q  <= bus.BRESP[1];
               end
               if (wr_done) state <= (b_done || bus.BVALID) ? RESP : WAIT_B;
            end
            WAIT_B: begin
               if (bus.BVALID) begin
                  err_q <= bus.BRESP[1];
                  state <= RESP;
               end
            end
            RD_ADDR: begin
               if (bus.ARREADY) begin
                  ar_valid <= 1'b0;
                  state    <= WAIT_R;
               end
            end
            WAIT_R: begin
               if (bus.RVALID) begin
                  rdata_q <= bus.RDATA;
                  err_q   <= bus.RRESP[1];
                  state   <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.REQ_READY = accept ? {grant, ~grant} : 2'b00;
   assign bus.RSP_VALID = (state == RESP) ? {grant_q, ~grant_q} : 2'b00;
   assign bus.RSP_RDATA = rdata_q;
   assign bus.RSP_ERR   = err_q;
   assign bus.AWADDR    = addr_q;
   assign bus.AWVALID   = aw_valid;
   assign bus.WDATA     = wdata_q;
   assign bus.WVALID    = w_valid;
   assign bus.WLAST     = w_valid;
   assign bus.ARADDR    = addr_q;
   assign bus.ARVALID   = ar_valid;
   assign bus.RREADY    = (state == WAIT_R);

   // Single-beat transfers: RLAST and the low response bits carry no information here.
   assign unused_ok = ^{bus.RLAST, bus.BRESP[0], bus.RRESP[0]};
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Self-checking bench for axi_mem_arbiter: a latency-programmable AXI slave model, two client queues
// and a response scoreboard, driven by a vector table plus hand-written corner-case sequences.
module tb_axi_mem_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi_mem_arbiter_if #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) bus ();
   axi_mem_arbiter #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      bit          port;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ar_w, aw_w, w_w, b_w, r_w;
      logic [1:0]  resp;
      int          lat;
   } vec_t;

   int checks = 0;
   int failures = 0;

   req_t q0[$];
   req_t q1[$];
   exp_t sb[$];
   bit   glog[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] slv_mem [logic [31:0]];
   logic [31:0] ref_last;

   // slave knobs and state
   int ar_wait, aw_wait, w_wait, b_wait, r_wait;
   logic [1:0] resp_cfg;
   bit b_early;
   int ar_cnt, aw_cnt, w_cnt, b_cnt, r_cnt;
   bit r_pend, b_pend, aw_seen, w_seen;
   logic [31:0] r_addr, w_addr, w_dat;

   // per-scenario observations
   int cyc;
   int acc_c[8];
   int rsp_c[8];
   int n_acc, n_rsp;
   int arhs_cyc, awhs_cyc, whs_cyc, rv_cyc, bv_cyc;
   int proto, spurious;
   logic        tr_arv[64];
   logic        tr_awv[64];
   logic        tr_wv[64];
   logic [31:0] tr_araddr[64];
   logic        p_arv, p_awv, p_wv, p_arhs, p_awhs, p_whs;
   logic [31:0] p_araddr, p_awaddr, p_wdata;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] slv_rd(input logic [31:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      ref_mem[a] = d;
      slv_mem[a] = d;
   endtask

   task automatic drive_idle();
      bus.REQ_VALID = 2'b00; bus.REQ_WE = 2'b00; bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;
      bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;
      bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00; bus.RLAST = 1'b0;
   endtask

   task automatic start_scn(input int ar, input int aw, input int w, input int b, input int r,
                            input logic [1:0] resp, input bit early);
      ar_wait = ar; aw_wait = aw; w_wait = w; b_wait = b; r_wait = r;
      resp_cfg = resp; b_early = early;
      cyc = 0; n_acc = 0; n_rsp = 0; proto = 0; spurious = 0;
      arhs_cyc = -1; awhs_cyc = -1; whs_cyc = -1; rv_cyc = -1; bv_cyc = -1;
      for (int k = 0; k < 8; k++) begin acc_c[k] = -1; rsp_c[k] = -1; end
      glog.delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      q0.delete(); q1.delete(); sb.delete();
      r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
      p_arv = 0; p_awv = 0; p_wv = 0; p_arhs = 0; p_awhs = 0; p_whs = 0;
      ref_last = 32'h0;
      @(negedge clk);
      check("rst_req_ready", bus.REQ_READY, 2'b00);
      check("rst_rsp_valid", bus.RSP_VALID, 2'b00);
      check("rst_valids", {bus.AWVALID, bus.WVALID, bus.WLAST, bus.ARVALID, bus.RREADY}, 5'b0);
      check("rst_awaddr", bus.AWADDR, 32'h0);
      check("rst_araddr", bus.ARADDR, 32'h0);
      check("rst_wdata", bus.WDATA, 32'h0);
      check("rst_rsp_rdata", bus.RSP_RDATA, 32'h0);
      check("rst_rsp_err", bus.RSP_ERR, 1'b0);
      rst = 1'b0;
   endtask

   task automatic accept_req(input bit port, input req_t r);
      exp_t e;
      e.port = port;
      e.err  = resp_cfg[1];
      if (r.we) begin
         ref_mem[r.addr] = r.wdata;
         e.rdata = ref_last;
      end else begin
         e.rdata  = ref_rd(r.addr);
         ref_last = e.rdata;
      end
      sb.push_back(e);
      glog.push_back(port);
      if (n_acc < 8) acc_c[n_acc] = cyc;
      n_acc++;
   endtask

   // One clock: slave and clients drive at the falling edge, outputs are sampled there as well.
   task automatic step();
      req_t r;
      exp_t e;
      logic [1:0] rr;
      @(negedge clk);
      bus.RVALID = 1'b0; bus.BVALID = 1'b0; bus.ARREADY = 1'b0; bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
      if (r_pend) begin
         if (r_cnt >= r_wait) begin
            bus.RVALID = 1'b1; bus.RDATA = slv_rd(r_addr); bus.RRESP = resp_cfg; bus.RLAST = 1'b1;
            if (rv_cyc < 0) rv_cyc = cyc;
            if (bus.RREADY) r_pend = 0;
         end else r_cnt++;
      end
      if (b_pend) begin
         if (b_cnt >= b_wait) begin
            bus.BVALID = 1'b1; bus.BRESP = resp_cfg; b_pend = 0;
            if (bv_cyc < 0) bv_cyc = cyc;
         end else b_cnt++;
      end
      if (bus.ARVALID) begin
         if (ar_cnt >= ar_wait) begin
            bus.ARREADY = 1'b1; ar_cnt = 0; r_pend = 1; r_cnt = 0; r_addr = bus.ARADDR;
            if (arhs_cyc < 0) arhs_cyc = cyc;
         end else ar_cnt++;
      end
      if (bus.AWVALID) begin
         if (aw_cnt >= aw_wait) begin
            bus.AWREADY = 1'b1; aw_cnt = 0; aw_seen = 1; w_addr = bus.AWADDR;
            if (awhs_cyc < 0) awhs_cyc = cyc;
         end else aw_cnt++;
      end
      if (bus.WVALID) begin
         if (w_cnt >= w_wait) begin
            bus.WREADY = 1'b1; w_cnt = 0; w_seen = 1; w_dat = bus.WDATA;
            if (whs_cyc < 0) whs_cyc = cyc;
         end else w_cnt++;
      end
      if (aw_seen && w_seen) begin
         slv_mem[w_addr] = w_dat;
         aw_seen = 0; w_seen = 0;
         if (b_early) begin
            bus.BVALID = 1'b1; bus.BRESP = resp_cfg;
            if (bv_cyc < 0) bv_cyc = cyc;
         end else begin
            b_pend = 1; b_cnt = 0;
         end
      end

      bus.REQ_VALID = {q1.size() != 0, q0.size() != 0};
      if (q0.size() != 0) begin
         bus.REQ_WE[0] = q0[0].we; bus.REQ_ADDR[31:0] = q0[0].addr; bus.REQ_WDATA[31:0] = q0[0].wdata;
      end
      if (q1.size() != 0) begin
         bus.REQ_WE[1] = q1[0].we; bus.REQ_ADDR[63:32] = q1[0].addr; bus.REQ_WDATA[63:32] = q1[0].wdata;
      end
      #1;
      rr = bus.REQ_READY;
      if (rr == 2'b11 || (rr & ~bus.REQ_VALID) != 2'b00) proto++;
      if (rr[0] && bus.REQ_VALID[0]) begin r = q0.pop_front(); accept_req(1'b0, r); end
      if (rr[1] && bus.REQ_VALID[1]) begin r = q1.pop_front(); accept_req(1'b1, r); end

      if (p_arv && !p_arhs && (bus.ARVALID !== 1'b1 || bus.ARADDR !== p_araddr)) proto++;
      if (p_awv && !p_awhs && (bus.AWVALID !== 1'b1 || bus.AWADDR !== p_awaddr)) proto++;
      if (p_wv && !p_whs && (bus.WVALID !== 1'b1 || bus.WDATA !== p_wdata)) proto++;
      if (bus.WLAST !== bus.WVALID) proto++;
      p_arv = bus.ARVALID; p_arhs = bus.ARVALID && bus.ARREADY; p_araddr = bus.ARADDR;
      p_awv = bus.AWVALID; p_awhs = bus.AWVALID && bus.AWREADY; p_awaddr = bus.AWADDR;
      p_wv = bus.WVALID; p_whs = bus.WVALID && bus.WREADY; p_wdata = bus.WDATA;
      if (cyc < 64) begin
         tr_arv[cyc] = bus.ARVALID; tr_araddr[cyc] = bus.ARADDR;
         tr_awv[cyc] = bus.AWVALID; tr_wv[cyc] = bus.WVALID;
      end

      if (bus.RSP_VALID != 2'b00) begin
         if (n_rsp < 8) rsp_c[n_rsp] = cyc;
         n_rsp++;
         if (sb.size() == 0) spurious++;
         else begin
            e = sb.pop_front();
            check("rsp_valid", bus.RSP_VALID, e.port ? 2'b10 : 2'b01);
            check("rsp_rdata", bus.RSP_RDATA, e.rdata);
            check("rsp_err", bus.RSP_ERR, e.err);
         end
      end
      cyc++;
   endtask

   task automatic run_idle(input string name, input int budget);
      int n = 0;
      while ((q0.size() + q1.size() + sb.size()) != 0 && n < budget) begin
         step();
         n++;
      end
      check({name, "_done"}, (q0.size() + q1.size() + sb.size()) != 0, 1'b0);
      check({name, "_protocol"}, proto, 0);
      check({name, "_spurious"}, spurious, 0);
   endtask

   function automatic req_t mk(input bit we, input logic [31:0] a, input logic [31:0] d);
      req_t r;
      r.we = we; r.addr = a; r.wdata = d;
      return r;
   endfunction

   initial begin
      logic [7:0]  order;
      logic [3:0]  wv;
      logic [10:0] arv;
      int          t;
      int          bad;

      rst = 1'b1;
      drive_idle();
      preload(32'h100, 32'hDEADBEEF);
      preload(32'h104, 32'h0BADF00D);
      for (int k = 0; k < 8; k++) preload(32'h400 + 32'(4 * k), 32'h1000_0000 + 32'(k));

      vecs[0] = '{0, 0, 32'h100, 32'h0,         0, 0, 0, 0, 0, 2'b00, 3};
      vecs[1] = '{1, 1, 32'h200, 32'h12345678,  0, 0, 3, 0, 0, 2'b10, 6};
      vecs[2] = '{1, 0, 32'h200, 32'h0,         2, 0, 0, 0, 1, 2'b00, 6};
      vecs[3] = '{0, 1, 32'h300, 32'hA5A50F0F,  0, 4, 1, 2, 0, 2'b00, 9};
      vecs[4] = '{0, 0, 32'h300, 32'h0,         0, 0, 0, 0, 0, 2'b11, 3};
      vecs[5] = '{1, 1, 32'h104, 32'h55AA55AA,  0, 1, 0, 0, 0, 2'b00, 4};
      vecs[6] = '{1, 0, 32'h104, 32'h0,         0, 0, 0, 0, 3, 2'b01, 6};

      apply_reset();

      // Fairness from reset: both clients always valid, four reads each.
      start_scn(0, 0, 0, 0, 0, 2'b00, 0);
      for (int k = 0; k < 4; k++) begin
         q0.push_back(mk(0, 32'h400 + 32'(4 * k), 32'h0));
         q1.push_back(mk(0, 32'h410 + 32'(4 * k), 32'h0));
      end
      run_idle("fair", 200);
      order = '0;
      for (int k = 0; k < 8 && k < glog.size(); k++) order[k] = glog[k];
      check("fair_count", glog.size(), 8);
      check("fair_order", order, 8'hAA);

      // Table of single transactions with varied slave latencies and responses.
      for (int i = 0; i < 7; i++) begin
         start_scn(vecs[i].ar_w, vecs[i].aw_w, vecs[i].w_w, vecs[i].b_w, vecs[i].r_w, vecs[i].resp, 0);
         if (vecs[i].port) q1.push_back(mk(vecs[i].we, vecs[i].addr, vecs[i].wdata));
         else              q0.push_back(mk(vecs[i].we, vecs[i].addr, vecs[i].wdata));
         run_idle($sformatf("vec%0d", i), 100);
         check($sformatf("vec%0d_latency", i), rsp_c[0] - acc_c[0], vecs[i].lat);
      end

      // Zero-wait read then a queued second read on the same client.
      preload(32'h100, 32'hDEADBEEF);
      start_scn(0, 0, 0, 0, 0, 2'b00, 0);
      q0.push_back(mk(0, 32'h100, 32'h0));
      q0.push_back(mk(0, 32'h104, 32'h0));
      run_idle("rd0", 50);
      t = acc_c[0];
      check("rd0_ar_hs", arhs_cyc - t, 1);
      check("rd0_araddr", tr_araddr[arhs_cyc & 63], 32'h100);
      check("rd0_rsp", rsp_c[0] - t, 3);
      check("rd0_next_ready", acc_c[1] - t, 4);

      // Write with AW ready at once and W ready three cycles later, error response.
      start_scn(0, 0, 3, 0, 0, 2'b10, 0);
      q1.push_back(mk(1, 32'h200, 32'h12345678));
      run_idle("wr1", 50);
      t = acc_c[0];
      for (int k = 0; k < 4; k++) wv[k] = tr_wv[t + 1 + k];
      check("wr1_aw_hs", awhs_cyc - t, 1);
      check("wr1_awvalid_dropped", tr_awv[t + 2], 1'b0);
      check("wr1_wvalid_held", wv, 4'hF);
      check("wr1_w_hs", whs_cyc - t, 4);
      check("wr1_rsp", rsp_c[0] - t, 6);
      check("wr1_slave_mem", slv_rd(32'h200), 32'h12345678);

      // ARREADY low for ten cycles.
      start_scn(10, 0, 0, 0, 0, 2'b00, 0);
      q1.push_back(mk(0, 32'h104, 32'h0));
      run_idle("arstall", 80);
      t = acc_c[0];
      bad = 0;
      for (int k = 0; k < 11; k++) begin
         arv[k] = tr_arv[t + 1 + k];
         if (tr_araddr[t + 1 + k] !== 32'h104) bad++;
      end
      check("arstall_arvalid", arv, 11'h7FF);
      check("arstall_araddr_stable", bad, 0);
      check("arstall_ar_hs", arhs_cyc - t, 11);
      check("arstall_rsp_after_hs", rsp_c[0] - arhs_cyc, 2);
      check("arstall_rsp_after_rvalid", rsp_c[0] - rv_cyc, 1);

      // AWREADY, WREADY and BVALID together.
      start_scn(0, 0, 0, 0, 0, 2'b00, 1);
      q0.push_back(mk(1, 32'h300, 32'hCAFEF00D));
      run_idle("earlyb", 50);
      repeat (5) step();
      t = acc_c[0];
      check("earlyb_bvalid", bv_cyc - t, 1);
      check("earlyb_rsp", rsp_c[0] - t, 2);
      check("earlyb_rsp_once", n_rsp, 1);
      check("earlyb_spurious", spurious, 0);

      // Reset while waiting for read data, then a tie goes to client 0.
      start_scn(0, 0, 0, 0, 6, 2'b00, 0);
      q0.push_back(mk(0, 32'h100, 32'h0));
      repeat (4) step();
      check("rstmid_ar_hs", arhs_cyc - acc_c[0], 1);
      apply_reset();
      start_scn(0, 0, 0, 0, 0, 2'b00, 0);
      repeat (8) step();
      check("rstmid_no_rsp", n_rsp, 0);
      q0.push_back(mk(0, 32'h104, 32'h0));
      q1.push_back(mk(0, 32'h100, 32'h0));
      run_idle("rstmid_tie", 50);
      check("rstmid_first_grant", (glog.size() != 0) ? glog[0] : 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
